// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES-256 decryption datapath: widths, the
// stage FSM encoding and a helper that picks one 32-bit column out of a block.
package aes_dec_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_COL_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_DONE = 2'd2
  } stage_state_e;

  // Column 0 sits in the most significant 32 bits of the block.
  function automatic logic [AES_COL_W-1:0] col_sel(input logic [AES_BLK_W-1:0] blk,
                                                   input logic [1:0]           idx);
    return blk[AES_BLK_W-1 - AES_COL_W*int'(idx) -: AES_COL_W];
  endfunction

endpackage

// File: rtl/inv_ark_mixcol_stage_helper.sv
// InvMixColumns on a single column. Purely combinational.
// Byte 0 of the column is the MSB; the matrix rows are [e b d 9] rotated.
module MixColumnHelper
  import aes_dec_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_in,
  output logic [AES_COL_W-1:0] col_out
);

  // Multiply by x in GF(2^8) with the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Each output byte is one row of the inverse mix matrix applied to the column.
  always_comb begin
    col_out[31:24] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
    col_out[23:16] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
    col_out[15:8]  = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
    col_out[7:0]   = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
  end

endmodule

// File: rtl/inv_ark_mixcol_stage.sv
// AddRoundKey followed by column-serial InvMixColumns for AES-256 decryption.
// The XOR is applied on acceptance; the mix then rewrites COLS_PER_CYCLE
// columns of the working register per clock, and the result is held in DONE
// until the downstream stage takes it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never waits on ready, and once out_valid is raised the data on
// out_state stays stable until that transfer.
module inv_ark_mixcol_stage
  import aes_dec_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_state,
  input  logic [127:0]   in_key,
  input  logic           skip_mix,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_state,
  output logic           busy,
  output logic [1:0]     dbg_state,
  output logic           dbg_skip
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_ark_mixcol_stage: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // With 4 columns per cycle the step wraps to 0 and the single group is also the last.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

  stage_state_e         state, state_nxt;
  logic [1:0]           col, col_nxt;
  logic [AES_BLK_W-1:0] work, work_nxt;
  logic                 skip_q, skip_nxt;

  logic [AES_COL_W-1:0] mix_in  [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0] mix_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
    assign mix_in[g] = col_sel(work, col + 2'(g));

    MixColumnHelper u_mix (
      .col_in  (mix_in[g]),
      .col_out (mix_out[g])
    );
  end

  // Next-state, working-register update and handshake outputs.
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    state_nxt = state;
    col_nxt   = col;
    work_nxt  = work;
    skip_nxt  = skip_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          work_nxt  = in_state ^ in_key;
          skip_nxt  = skip_mix;
          col_nxt   = 2'd0;
          state_nxt = skip_mix ? ST_DONE : ST_MIX;
        end
      end
      ST_MIX: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          idx = col + 2'(g);
          work_nxt[AES_BLK_W-1 - AES_COL_W*int'(idx) -: AES_COL_W] = mix_out[g];
        end
        col_nxt = col + COL_STEP;
        if (col == COL_LAST) begin
          col_nxt   = 2'd0;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State registers; reset clears everything so a partial block leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      col    <= 2'd0;
      work   <= '0;
      skip_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      col    <= col_nxt;
      work   <= work_nxt;
      skip_q <= skip_nxt;
    end
  end

  assign out_state = work;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;
  assign dbg_skip  = skip_q;

endmodule

// File: tb/tb_inv_ark_mixcol_stage.sv
// Bench for inv_ark_mixcol_stage: three instances (1, 2 and 4 columns per
// cycle) share clock and reset; each has its own driver inputs and its own
// expected-data and expected-latency queues, drained by one monitor.
module tb_inv_ark_mixcol_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals (index 0: C=1, 1: C=2, 2: C=4) ----------------
  logic         iv   [3];
  logic         ir   [3];
  logic [127:0] ist  [3];
  logic [127:0] ikey [3];
  logic         skp  [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] ost  [3];
  logic         bsy  [3];
  logic [1:0]   dst  [3];
  logic         dsk  [3];

  inv_ark_mixcol_stage #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_state(ist[0]), .in_key(ikey[0]), .skip_mix(skp[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(ost[0]),
    .busy(bsy[0]), .dbg_state(dst[0]), .dbg_skip(dsk[0])
  );

  inv_ark_mixcol_stage #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_state(ist[1]), .in_key(ikey[1]), .skip_mix(skp[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(ost[1]),
    .busy(bsy[1]), .dbg_state(dst[1]), .dbg_skip(dsk[1])
  );

  inv_ark_mixcol_stage #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_state(ist[2]), .in_key(ikey[2]), .skip_mix(skp[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(ost[2]),
    .busy(bsy[2]), .dbg_state(dst[2]), .dbg_skip(dsk[2])
  );

  // ---------------- vectors (hand-computed) ----------------
  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] R1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd5d5d7d6_4d7ebdf8_c6c6c6c6_01010101;
  localparam logic [127:0] R2 = 128'hd4d4d4d5_2d26314c_c6c6c6c6_01010101;
  localparam logic [127:0] K0 = 128'h00010203_04050607_08090a0b_0c0d0e0f;

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q [3][$];
  int           a_q   [3][$];
  int           lat_q [3][$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic         pv    [3];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: latency checked when out_valid rises, data checked at the handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) pv[d] = 1'b0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && !pv[d]) begin
          if (a_q[d].size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_valid dut%0d: out_valid high with no block pending", d);
          end else begin
            int a, l;
            a = a_q[d].pop_front();
            l = lat_q[d].pop_front();
            chk($sformatf("latency dut%0d", d), 128'(cyc - a), 128'(l));
          end
        end
        if (ov[d] && ordy[d]) begin
          if (exp_q[d].size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_output dut%0d: got %h, nothing expected", d, ost[d]);
          end else begin
            chk($sformatf("out_state dut%0d", d), ost[d], exp_q[d].pop_front());
          end
        end
        pv[d] = ov[d];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int d, input logic [127:0] st, input logic [127:0] key,
                       input logic sk, input logic [127:0] exp, input int lat);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    iv[d] = 1'b1; ist[d] = st; ikey[d] = key; skp[d] = sk;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ir[d]) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      a_q[d].push_back(cyc);
      lat_q[d].push_back(lat);
      exp_q[d].push_back(exp);
    end else begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout dut%0d: in_ready never high", d);
    end
    @(posedge clk); #1;
    iv[d] = 1'b0; skp[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 200; i++) begin
      if (exp_q[d].size() == 0) break;
      @(negedge clk);
    end
    if (exp_q[d].size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout dut%0d: %0d outputs missing", d, exp_q[d].size());
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] k, k2, s2;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ist[d] = '0; ikey[d] = '0; skp[d] = 1'b0; ordy[d] = 1'b1;
    end

    // Reset state
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst out_valid dut%0d", d), 128'(ov[d]), 128'(0));
      chk($sformatf("rst in_ready dut%0d", d),  128'(ir[d]), 128'(0));
      chk($sformatf("rst busy dut%0d", d),      128'(bsy[d]), 128'(0));
      chk($sformatf("rst out_state dut%0d", d), ost[d], 128'(0));
      chk($sformatf("rst state dut%0d", d),     128'(dst[d]), 128'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle in_ready dut0", 128'(ir[0]), 128'(1));

    // C=1: plain mix, AddRoundKey only, combined key+mix, second vector, skip random
    issue(0, V1, 128'(0), 1'b0, R1, 5);
    issue(0, 128'(0), K0, 1'b1, K0, 1);
    k = {$urandom, $urandom, $urandom, $urandom};
    issue(0, V1 ^ k, k, 1'b0, R1, 5);
    issue(0, V2, 128'(0), 1'b0, R2, 5);
    s2 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    issue(0, s2, k2, 1'b1, s2 ^ k2, 1);
    drain(0);

    // Backpressure: hold out_ready low while the block sits in DONE
    ordy[0] = 1'b0;
    issue(0, V1, 128'(0), 1'b0, R1, 5);
    for (int i = 0; i < 20; i++) begin
      if (ov[0]) break;
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp out_valid", 128'(ov[0]), 128'(1));
      chk("bp out_state", ost[0], R1);
      chk("bp in_ready",  128'(ir[0]), 128'(0));
      @(negedge clk);
    end
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp in_ready after handshake", 128'(ir[0]), 128'(1));
    chk("bp out_valid after handshake", 128'(ov[0]), 128'(0));
    drain(0);

    // Reset pulsed in cycle A+3 of a mix block
    issue(0, V1, 128'(0), 1'b0, R1, 5);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 128'(ov[0]), 128'(0));
    chk("midrst busy",      128'(bsy[0]), 128'(0));
    chk("midrst out_state", ost[0], 128'(0));
    chk("midrst in_ready",  128'(ir[0]), 128'(0));
    exp_q[0].delete();
    a_q[0].delete();
    lat_q[0].delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, V1, 128'(0), 1'b0, R1, 5);
    drain(0);

    // C=2 and C=4
    issue(1, V1, 128'(0), 1'b0, R1, 3);
    issue(2, V1, 128'(0), 1'b0, R1, 2);
    issue(1, V2 ^ k, k, 1'b0, R2, 3);
    issue(2, V2, 128'(0), 1'b0, R2, 2);
    issue(2, 128'(0), K0, 1'b1, K0, 1);
    drain(1);
    drain(2);

    // No latency entries may be left unmatched
    repeat (4) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("leftover dut%0d", d), 128'(a_q[d].size()), 128'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inv_ark_mixcol_stage.md
# inv_ark_mixcol_stage

Sequential AddRoundKey + InvMixColumns stage for the AES-256 decryption datapath. It accepts a 128-bit state from InvSubBytes and a 128-bit round key from the key-schedule buffer, and XORs them. Unless the round skips InvMixColumns, it then runs InvMixColumns column-serially through `COLS_PER_CYCLE` instances of `MixColumnHelper`. The result goes to the next round's InvShiftRows over a valid/ready handshake.

## Interface
- `COLS_PER_CYCLE`, default 1: columns transformed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream block present.
- `in_ready` output 1: stage can accept a block.
- `in_state` input 128: state; column 0 = [127:96], byte 0 of a column = MSB.
- `in_key` input 128: round key, same byte order.
- `skip_mix` input 1: sampled with the block; 1 = AddRoundKey only. Used for the first and last rounds.
- `out_valid` output 1: result available.
- `out_ready` input 1: downstream accepts.
- `out_state` output 128: result, driven directly from the working register.
- `busy` output 1: high in MIX or DONE.

## Operation
- FSM has three states: IDLE, MIX and DONE. Reset state is IDLE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`, the working register loads `in_state ^ in_key`, and `skip_mix` is latched.
  - Next state is DONE if `skip_mix` = 1, otherwise MIX with column counter `col` = 0.
- MIX:
  - Each cycle, columns `col` .. `col+COLS_PER_CYCLE-1` of the working register are replaced by the `MixColumnHelper` outputs. All other columns hold.
  - `col` increments by `COLS_PER_CYCLE` each cycle.
  - When the last column group is written, the next state is DONE and `col` returns to 0.
  - `in_valid` is ignored in this state.
- DONE:
  - `out_valid` = 1, and `out_state` is stable.
  - On `out_ready`, the next state is IDLE.
  - A new block is not accepted in the same cycle as the output handshake.
- Arithmetic:
  - InvMixColumns is the GF(2^8) matrix [e b d 9] with rotations, computed only inside the helper.
  - No widening; all values are bytes.
- Outputs:
  - `in_ready` = (state == IDLE) and is additionally forced to 0 while `rst_n` is low.
  - `out_valid` = (state == DONE).
- Reset asserted in any state, including mid-MIX:
  - Takes effect immediately: state IDLE, working register 0, `col` 0, latched `skip_mix` 0.
  - `out_valid` 0, `busy` 0, `out_state` 0.
  - The partial block is discarded; there is no output for it.
- `out_ready` high outside DONE has no effect.

## Timing
- Let cycle A be the cycle in which `in_valid && in_ready` is high.
- `skip_mix` = 1: `out_valid` first high in cycle A+1.
- `skip_mix` = 0: `out_valid` first high in cycle A+1+4/`COLS_PER_CYCLE`.
  - `COLS_PER_CYCLE` = 1 gives A+5; 2 gives A+3; 4 gives A+2.
- Maximum throughput is one block per 2+4/`COLS_PER_CYCLE` cycles (mix) or 2 cycles (skip), assuming `out_ready` is held high.
- Under backpressure, `out_valid` and `out_state` hold until handshake and `in_ready` stays 0.
- The only combinational path from the helpers ends at the working register. There is no input-to-output combinational path.

## Structure
- Shared package `aes_dec_pkg` holds:
  - the FSM state enum (IDLE/MIX/DONE);
  - the `AES_BLK_W` = 128 and `AES_COL_W` = 32 constants;
  - a column-select function (index to bit slice, column 0 at MSB).
- Sub-module: `MixColumnHelper`, instantiated `COLS_PER_CYCLE` times, each fed by a `col`-indexed mux.
- Column counter width is 2 bits.

## Test plan
- InvMixColumns, `COLS_PER_CYCLE` = 1:
  - Stimulus: `in_state` = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, `in_key` = 0, `skip_mix` = 0.
  - Required: `out_state` = db135345_f20a225c_01010101_c6c6c6c6, with `out_valid` first high in A+5.
- AddRoundKey only:
  - Stimulus: `in_state` = 0, `in_key` = 000102030405060708090a0b0c0d0e0f, `skip_mix` = 1.
  - Required: `out_state` = 000102030405060708090a0b0c0d0e0f in A+1.
- Combined key and mix:
  - Stimulus: `in_state` = 8e4da1bc_... ^ K with a random K, `in_key` = K.
  - Required: same result as the first scenario.
- Backpressure:
  - Stimulus: `out_ready` held low for 10 cycles in DONE.
  - Required: `out_valid` = 1, `out_state` unchanged and `in_ready` = 0 throughout; handshake on the cycle `out_ready` rises, and `in_ready` = 1 the next cycle.
- Reset mid-operation:
  - Stimulus: `rst_n` pulsed low during cycle A+3.
  - Required: `out_valid`, `busy` and `out_state` go to 0 immediately. After release, a fresh first-scenario block produces the correct result.
- `COLS_PER_CYCLE` = 4 and 2 with the first-scenario vectors:
  - Required: identical `out_state`, with `out_valid` in A+2 and A+3 respectively.
